// File: rtl/seq_shift_add_mult_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
// Optional feature macro used by this block: MULT_EARLY_TERM_EN.
package mult_pkg;

  localparam int MULT_N = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_shift_add_mult_if.sv
// Start/busy/done handshake and operand/product bus of the shift-add multiplier.
interface seq_shift_add_mult_if
  import mult_pkg::*;
#(
  parameter int N = MULT_N
);

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [2*N-1:0] p;

  modport master (output start, a, b, input busy, done, p);
  modport slave  (input start, a, b, output busy, done, p);

endinterface

// File: rtl/adder.sv
// Plain W-bit adder cell; carry-out is dropped.
module adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic [W-1:0] sum
);

  assign sum = op_a + op_b;

endmodule

// File: rtl/seq_shift_add_mult_ctrl.sv
// Sequencer for the shift-add multiplier: IDLE/RUN/DONE FSM plus iteration counter.
// Registered busy/done are decoded from the next state so they align with the state register.
module seq_mult_ctrl
  import mult_pkg::*;
#(
  parameter  int N     = MULT_N,
  localparam int CNT_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             last_iter,
  input  logic             mplier_zero,
  output logic             load,
  output logic             step,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] cnt
);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;
  logic             busy_nxt_s;
  logic             done_nxt_s;
  logic             load_s;
  logic             step_s;

  // State, iteration counter and handshake output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      if (load_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (step_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Next-state decode; start outside IDLE is deliberately dropped
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_iter || mplier_zero) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath strobes from the current state, handshake values from the next state
  always_comb begin
    load_s     = 1'b0;
    step_s     = 1'b0;
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: load_s = start;
      ST_RUN:  step_s = 1'b1;
      default: begin
        load_s = 1'b0;
        step_s = 1'b0;
      end
    endcase
    case (state_nxt_s)
      ST_RUN:  busy_nxt_s = 1'b1;
      ST_DONE: begin
        busy_nxt_s = 1'b1;
        done_nxt_s = 1'b1;
      end
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  assign load = load_s;
  assign step = step_s;
  assign done = done_r;
  assign busy = busy_r;
  assign cnt  = cnt_r;

endmodule

// File: rtl/seq_shift_add_mult.sv
// Iterative unsigned N x N shift-add multiplier reusing one 2N-bit adder.
// Define MULT_EARLY_TERM_EN to end RUN once the remaining multiplier bits are all zero.
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter  int N     = MULT_N,
  localparam int CNT_W = $clog2(N)
) (
  input logic                 clk,
  input logic                 rst,
  seq_shift_add_mult_if.slave bus
);

  logic [2*N-1:0] mcand_r;
  logic [N-1:0]   mplier_r;
  logic [2*N-1:0] acc_r;
  logic [2*N-1:0] p_r;
  logic [2*N-1:0] mcand_nxt_s;
  logic [N-1:0]   mplier_nxt_s;
  logic [2*N-1:0] acc_nxt_s;
  logic [2*N-1:0] acc_step_s;
  logic [2*N-1:0] sum_s;
  logic [CNT_W-1:0] cnt_s;
  logic           load_s;
  logic           step_s;
  logic           last_iter_s;
  logic           mplier_zero_s;
  logic           fin_s;
  logic           busy_s;
  logic           done_s;

  seq_mult_ctrl #(.N(N)) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .start       (bus.start),
    .last_iter   (last_iter_s),
    .mplier_zero (mplier_zero_s),
    .load        (load_s),
    .step        (step_s),
    .done        (done_s),
    .busy        (busy_s),
    .cnt         (cnt_s)
  );

  adder #(.W(2*N)) u_add (
    .op_a (acc_r),
    .op_b (mcand_r),
    .sum  (sum_s)
  );

  assign last_iter_s = (cnt_s == CNT_W'(N-1));

`ifdef MULT_EARLY_TERM_EN
  // Looks at the value being shifted in this edge, so the last useful add still lands
  assign mplier_zero_s = (mplier_r[N-1:1] == {(N-1){1'b0}});
`else
  assign mplier_zero_s = 1'b0;
`endif

  assign fin_s = step_s & (last_iter_s | mplier_zero_s);

  // Load-versus-step muxes for the shift registers and accumulator
  always_comb begin
    if (mplier_r[0]) begin
      acc_step_s = sum_s;
    end else begin
      acc_step_s = acc_r;
    end
    if (load_s) begin
      mcand_nxt_s  = {{N{1'b0}}, bus.a};
      mplier_nxt_s = bus.b;
      acc_nxt_s    = {(2*N){1'b0}};
    end else if (step_s) begin
      mcand_nxt_s  = {mcand_r[2*N-2:0], 1'b0};
      mplier_nxt_s = {1'b0, mplier_r[N-1:1]};
      acc_nxt_s    = acc_step_s;
    end else begin
      mcand_nxt_s  = mcand_r;
      mplier_nxt_s = mplier_r;
      acc_nxt_s    = acc_r;
    end
  end

  // Datapath registers; p only moves on the final RUN edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_r  <= {(2*N){1'b0}};
      mplier_r <= {N{1'b0}};
      acc_r    <= {(2*N){1'b0}};
      p_r      <= {(2*N){1'b0}};
    end else begin
      mcand_r  <= mcand_nxt_s;
      mplier_r <= mplier_nxt_s;
      acc_r    <= acc_nxt_s;
      if (fin_s) begin
        p_r <= acc_step_s;
      end else begin
        p_r <= p_r;
      end
    end
  end

  assign bus.busy = busy_s;
  assign bus.done = done_s;
  assign bus.p    = p_r;

endmodule
